// File: rtl/fifo_drain.sv
// fifo_drain: consumer-side engine for the synchronous FIFO protocol.
//
// Issues FIFO pops (rd_en) and captures rd_data one cycle after each pop
// into a 3-entry circular buffer. Buffered words are then re-presented on a
// downstream valid/ready stream. The buffer and in-flight accounting allow
// one word per cycle while keeping m_ready out of the rd_en path.
//
// Parameters:
//   DATA_WIDTH     word width, matches the FIFO
//   CNT_WIDTH      width of the delivered-word counter
// Ports:
//   clk            single clock, posedge
//   rst            synchronous active-high reset
//   en             drain enable; gates issue of new reads only
//   empty          FIFO empty status
//   full           FIFO full status (sets fifo_full_seen)
//   rd_data        FIFO read data, valid the cycle after rd_en
//   rd_en          FIFO pop request
//   m_valid        downstream word valid
//   m_data         downstream word
//   m_ready        downstream accept
//   pop_count      words delivered since reset (wraps)
//   busy           a word is in flight or buffered
//   fifo_full_seen sticky: full sampled high since reset

package fifo_pkg;
    localparam int unsigned DATA_WIDTH = 8;
endpackage

module fifo_drain #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  empty,
    input  logic                  full,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic                  busy,
    output logic                  fifo_full_seen
);

    localparam int unsigned DEPTH = 3;

    logic                  inflight;
    logic [DATA_WIDTH-1:0] entries [DEPTH];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [1:0]            count;

    logic                  capture;
    logic                  deliver;
    logic [2:0]            occupancy;

    // Pointers step through 0,1,2 and wrap back to 0.
    function automatic logic [1:0] next_ptr(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Issue is decided from registered state plus en/empty only, so the
    // downstream m_ready never reaches rd_en combinationally. Counting the
    // in-flight word reserves its buffer slot before it arrives.
    // Outputs are forced low while rst is high so they are defined from the
    // first reset cycle onwards.
    always_comb begin
        occupancy = {1'b0, count} + {2'b00, inflight};
        capture   = inflight;
        rd_en     = !rst && en && !empty && (occupancy < 3'd3);
        m_valid   = !rst && (count != 2'd0);
        m_data    = rst ? '0 : entries[rd_ptr];
        busy      = !rst && (inflight || (count != 2'd0));
        deliver   = m_valid && m_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight       <= 1'b0;
            count          <= 2'd0;
            wr_ptr         <= 2'd0;
            rd_ptr         <= 2'd0;
            pop_count      <= '0;
            fifo_full_seen <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            inflight <= rd_en;

            if (capture) begin
                entries[wr_ptr] <= rd_data;
                wr_ptr          <= next_ptr(wr_ptr);
            end

            if (deliver) begin
                rd_ptr    <= next_ptr(rd_ptr);
                pop_count <= pop_count + CNT_WIDTH'(1);
            end

            // Capture and delivery in the same cycle leave count unchanged.
            case ({capture, deliver})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (full) begin
                fifo_full_seen <= 1'b1;
            end
        end
    end

    // The issue rule guarantees a free slot for every captured word.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(capture && !deliver && (count == 2'd3)));

    a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(rd_en && empty));

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        count <= 2'd3);

endmodule

// File: tb/tb_fifo_drain.sv
module tb_fifo_drain;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       empty;
    logic       full;
    logic [7:0] rd_data;
    logic       m_ready;

    logic        rd_en, m_valid, busy, fifo_full_seen;
    logic [7:0]  m_data;
    logic [15:0] pop_count;

    logic        rd_en4, m_valid4, busy4, fifo_full_seen4;
    logic [7:0]  m_data4;
    logic [3:0]  pop_count4;

    always #5 clk = ~clk;

    fifo_drain #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .en(en), .empty(empty), .full(full),
        .rd_data(rd_data), .rd_en(rd_en), .m_valid(m_valid), .m_data(m_data),
        .m_ready(m_ready), .pop_count(pop_count), .busy(busy),
        .fifo_full_seen(fifo_full_seen)
    );

    // Second instance with a 4-bit counter for the wrap check.
    fifo_drain #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .empty(empty), .full(full),
        .rd_data(rd_data), .rd_en(rd_en4), .m_valid(m_valid4), .m_data(m_data4),
        .m_ready(m_ready), .pop_count(pop_count4), .busy(busy4),
        .fifo_full_seen(fifo_full_seen4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // FIFO model contents, and words popped but not yet delivered.
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];

    int         cyc, n_rd, n_deliv, first_rd, first_valid, last_deliv, empty_viol;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic reset_stats();
        cyc = 0; n_rd = 0; n_deliv = 0; first_rd = -1; first_valid = -1;
        last_deliv = -1; empty_viol = 0;
    endtask

    task automatic push_words(input int n);
        for (int i = 1; i <= n; i++) fifo_q.push_back(8'(i));
        empty = (fifo_q.size() == 0);
    endtask

    // One clock: sample outputs mid-cycle, then after the edge let the FIFO
    // model present the popped word on rd_data.
    task automatic cycle();
        logic pop;
        #1;
        if (rd_en && empty) empty_viol++;
        if (rd_en) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
        end
        if (m_valid && first_valid < 0) first_valid = cyc;
        if (prev_stall && !rst) begin
            check("stall_valid", 32'(m_valid), 32'd1);
            check("stall_data", 32'(m_data), 32'(prev_data));
        end
        if (m_valid && m_ready) begin
            n_deliv++;
            last_deliv = cyc;
            if (exp_q.size() == 0) check("spurious_delivery", 32'(m_valid), 32'd0);
            else check("order", 32'(m_data), 32'(exp_q.pop_front()));
        end
        prev_stall = m_valid && !m_ready && !rst;
        prev_data  = m_data;
        pop = rd_en;
        @(posedge clk);
        #1;
        if (pop && fifo_q.size() > 0) begin
            rd_data = fifo_q.pop_front();
            exp_q.push_back(rd_data);
        end
        empty = (fifo_q.size() == 0);
        cyc++;
        @(negedge clk);
    endtask

    // FIFO is reset alongside the DUT, so model contents are discarded.
    task automatic pulse_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        empty = 1'b1;
        rd_data = '0;
        prev_stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; empty = 1'b1; full = 1'b0; m_ready = 1'b1; rd_data = '0;
        reset_stats();
        @(negedge clk);

        // Reset held 3 cycles with words available and en high
        push_words(8);
        repeat (3) begin
            #1;
            check("rst_rd_en", 32'(rd_en), 32'd0);
            check("rst_m_valid", 32'(m_valid), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            cycle();
        end
        check("rst_pop_count", 32'(pop_count), 32'd0);
        rst = 1'b0;
        reset_stats();
        #1;
        check("rd_en_after_rst", 32'(rd_en), 32'd1);

        // Streaming 0x01..0x08
        repeat (12) cycle();
        check("stream_first_rd", 32'(first_rd), 32'd0);
        check("stream_latency", 32'(first_valid - first_rd), 32'd2);
        check("stream_deliv", 32'(n_deliv), 32'd8);
        check("stream_consecutive", 32'(last_deliv - first_valid), 32'd7);
        check("stream_pop_count", 32'(pop_count), 32'd8);
        check("stream_busy", 32'(busy), 32'd0);

        // Backpressure: 6 words, m_ready low
        pulse_reset();
        reset_stats();
        push_words(6);
        m_ready = 1'b0;
        repeat (8) cycle();
        check("bp_rd_pulses", 32'(n_rd), 32'd3);
        check("bp_rd_en_low", 32'(rd_en), 32'd0);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_m_data", 32'(m_data), 32'h01);
        check("bp_fifo_left", 32'(fifo_q.size()), 32'd3);
        m_ready = 1'b1;
        repeat (10) cycle();
        check("bp_deliv", 32'(n_deliv), 32'd6);
        check("bp_pop_count", 32'(pop_count), 32'd6);
        check("bp_busy", 32'(busy), 32'd0);

        // Enable gating: en dropped one cycle after the first rd_en
        pulse_reset();
        reset_stats();
        push_words(4);
        cycle();
        en = 1'b0;
        repeat (6) cycle();
        check("en_rd_pulses", 32'(n_rd), 32'd1);
        check("en_deliv", 32'(n_deliv), 32'd1);
        check("en_fifo_left", 32'(fifo_q.size()), 32'd3);
        check("en_busy", 32'(busy), 32'd0);
        en = 1'b1;
        repeat (8) cycle();
        check("en_resume_deliv", 32'(n_deliv), 32'd4);
        check("en_pop_count", 32'(pop_count), 32'd4);

        // Single word with random m_ready
        pulse_reset();
        reset_stats();
        push_words(1);
        repeat (20) begin
            m_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        m_ready = 1'b1;
        repeat (3) cycle();
        check("uf_empty_viol", 32'(empty_viol), 32'd0);
        check("uf_rd_pulses", 32'(n_rd), 32'd1);
        check("uf_deliv", 32'(n_deliv), 32'd1);

        // full flag, pop_count wrap, reset mid-stream
        pulse_reset();
        reset_stats();
        check("full_seen_init", 32'(fifo_full_seen), 32'd0);
        full = 1'b1;
        cycle();
        full = 1'b0;
        repeat (2) cycle();
        check("full_seen_set", 32'(fifo_full_seen), 32'd1);
        push_words(17);
        repeat (24) cycle();
        check("wrap_deliv", 32'(n_deliv), 32'd17);
        check("wrap_pop16", 32'(pop_count), 32'd17);
        check("wrap_pop4", 32'(pop_count4), 32'd1);
        check("full_seen_hold", 32'(fifo_full_seen), 32'd1);
        push_words(4);
        m_ready = 1'b0;
        repeat (3) cycle();
        check("mid_m_valid", 32'(m_valid), 32'd1);
        check("mid_busy", 32'(busy), 32'd1);
        pulse_reset();
        check("mid_rst_m_valid", 32'(m_valid), 32'd0);
        check("mid_rst_pop16", 32'(pop_count), 32'd0);
        check("mid_rst_pop4", 32'(pop_count4), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_full_seen", 32'(fifo_full_seen), 32'd0);
        repeat (2) cycle();
        check("mid_rst_idle", 32'(m_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
